// File: rtl/digit_shift_buffer_if.sv
// Bus between the keypad decoder (master) and the digit shift buffer (slave).
// The master drives the operation strobes and the symbol to push.
// The slave returns the stored entries and the occupancy status.
interface digit_shift_buffer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   en;
    logic                   clr;
    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       dataIn;
    logic [DEPTH*WIDTH-1:0] dataOut;
    logic [WIDTH-1:0]       lastOut;
    logic [CW-1:0]          count;
    logic                   empty;
    logic                   full;
    logic                   overflow;

    modport master (
        output en, clr, push, pop, dataIn,
        input  dataOut, lastOut, count, empty, full, overflow
    );

    modport slave (
        input  en, clr, push, pop, dataIn,
        output dataOut, lastOut, count, empty, full, overflow
    );
endinterface

// File: rtl/digit_shift_buffer.sv
// Multi-entry symbol register for keypad entry, such as a PIN or an amount.
// Entry 0 is the newest symbol. A push shifts toward higher indices and a pop
// (backspace) shifts toward index 0. Entries at or above count are always zero.
// When full, SATURATE=1 ignores a push and SATURATE=0 drops the oldest entry.
// Either way the sticky overflow flag is set. Every output comes from a register.
// DEPTH must be at least 2.
module digit_shift_buffer #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    digit_shift_buffer_if.slave bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam bit SAT = (SATURATE != 0);

    logic [WIDTH-1:0]       r_entry [DEPTH];
    logic [CW-1:0]          r_count;
    logic                   r_overflow;

    logic [WIDTH-1:0]       w_entry_nxt [DEPTH];
    logic [CW-1:0]          w_count_nxt;
    logic                   w_overflow_nxt;
    logic                   w_empty;
    logic                   w_full;
    logic [DEPTH*WIDTH-1:0] w_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Next-state decode for push/pop. clr and en are applied in the register block.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        w_entry_nxt    = r_entry;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        if (bus.push && bus.pop && !w_empty) begin
            // Replace the newest symbol in place. Occupancy and overflow are unchanged.
            w_entry_nxt[0] = bus.dataIn;
        end else if (bus.push) begin
            if (w_full) begin
                w_overflow_nxt = 1'b1;
            end
            if (!w_full || !SAT) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    w_entry_nxt[i] = r_entry[i-1];
                end
                w_entry_nxt[0] = bus.dataIn;
                if (!w_full) begin
                    w_count_nxt = r_count + CW'(1);
                end
            end
        end else if (bus.pop && !w_empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_entry_nxt[i] = r_entry[i+1];
            end
            w_entry_nxt[DEPTH-1] = '0;
            w_count_nxt = r_count - CW'(1);
        end
    end

    // State registers. Priority is rst, then clr, then enable.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the entries are plain flops, not a RAM. Resetting them keeps the
        // "unused entries are zero" invariant true from the first cycle.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.en) begin
            // NOTE: non-blocking assignments so every flop updates from pre-edge values.
            r_entry    <= w_entry_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Pack the entries into the flat output word, with entry i at [i*WIDTH +: WIDTH].
    always_comb begin
        w_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_data[i*WIDTH +: WIDTH] = r_entry[i];
        end
    end

    assign bus.dataOut  = w_data;
    assign bus.lastOut  = r_entry[0];
    assign bus.count    = r_count;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_digit_shift_buffer.sv
// Self-checking bench for digit_shift_buffer.
// Two instances receive identical stimulus: one with SATURATE=1, one with SATURATE=0.
// The reference model treats the buffer as a base-2^W number: a push multiplies
// by 2^W and adds the symbol, and a pop divides by 2^W.
module tb_digit_shift_buffer;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int DW = W * D;
    localparam logic [DW:0] MOD = {1'b1, {DW{1'b0}}};  // 2^DW

    logic clk = 1'b0;
    logic rst = 1'b0;

    digit_shift_buffer_if #(.WIDTH(W), .DEPTH(D)) if_sat ();
    digit_shift_buffer_if #(.WIDTH(W), .DEPTH(D)) if_drop ();

    digit_shift_buffer #(.WIDTH(W), .DEPTH(D), .SATURATE(1)) u_sat  (.clk(clk), .rst(rst), .bus(if_sat));
    digit_shift_buffer #(.WIDTH(W), .DEPTH(D), .SATURATE(0)) u_drop (.clk(clk), .rst(rst), .bus(if_drop));

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state. Index 0 is the saturating instance, index 1 the drop-oldest one.
    logic [DW-1:0] m_val [2];
    int            m_cnt [2];
    bit            m_ovf [2];

    typedef struct {
        bit            en, clr, push, pop;
        logic [W-1:0]  din;
        logic [DW-1:0] exp_data [2];
        int            exp_cnt  [2];
        bit            exp_ovf  [2];
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of one instance against the given expected state.
    task automatic check_dut(input int k, input string tag, input logic [DW-1:0] data,
                             input int cnt, input bit ovf);
        logic [DW-1:0] a_data;
        logic [W-1:0]  a_last;
        logic [31:0]   a_cnt;
        logic          a_empty, a_full, a_ovf;
        string         who;
        if (k == 0) begin
            a_data = if_sat.dataOut;  a_last = if_sat.lastOut;  a_cnt = 32'(if_sat.count);
            a_empty = if_sat.empty;   a_full = if_sat.full;     a_ovf = if_sat.overflow;
            who = "sat";
        end else begin
            a_data = if_drop.dataOut; a_last = if_drop.lastOut; a_cnt = 32'(if_drop.count);
            a_empty = if_drop.empty;  a_full = if_drop.full;    a_ovf = if_drop.overflow;
            who = "drop";
        end
        check({tag, " ", who, " dataOut"},  32'(a_data),  32'(data));
        check({tag, " ", who, " lastOut"},  32'(a_last),  32'(data[W-1:0]));
        check({tag, " ", who, " count"},    a_cnt,        32'(cnt));
        check({tag, " ", who, " empty"},    32'(a_empty), 32'(cnt == 0));
        check({tag, " ", who, " full"},     32'(a_full),  32'(cnt == D));
        check({tag, " ", who, " overflow"}, 32'(a_ovf),   32'(ovf));
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 2; k++) check_dut(k, tag, m_val[k], m_cnt[k], m_ovf[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = '0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
        end
    endtask

    // One clock of the reference model for both overflow policies.
    task automatic model_step(input bit en, input bit clr, input bit push, input bit pop,
                              input logic [W-1:0] din);
        logic [DW:0] wide;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_val[k] = '0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
            end else if (en) begin
                if (push && pop && m_cnt[k] > 0) begin
                    m_val[k] = (m_val[k] / (1 << W)) * (1 << W) + DW'(din);
                end else if (push) begin
                    if (m_cnt[k] == D) m_ovf[k] = 1'b1;
                    if (m_cnt[k] < D || k == 1) begin
                        wide     = ({1'b0, m_val[k]} * (1 << W) + (DW+1)'(din)) % MOD;
                        m_val[k] = wide[DW-1:0];
                        if (m_cnt[k] < D) m_cnt[k]++;
                    end
                end else if (pop && m_cnt[k] > 0) begin
                    m_val[k] = m_val[k] / (1 << W);
                    m_cnt[k]--;
                end
            end
        end
    endtask

    // Drive inputs on the falling edge, clock them in, and sample 1 ns after the rising edge.
    task automatic step(input bit en, input bit clr, input bit push, input bit pop,
                        input logic [W-1:0] din);
        @(negedge clk);
        if_sat.en  = en;  if_sat.clr  = clr;  if_sat.push  = push;  if_sat.pop  = pop;  if_sat.dataIn  = din;
        if_drop.en = en;  if_drop.clr = clr;  if_drop.push = push;  if_drop.pop = pop;  if_drop.dataIn = din;
        @(posedge clk);
        #1;
        model_step(en, clr, push, pop, din);
    endtask

    vec_t vecs [18];

    task automatic set_vec(input int i, input bit en, input bit clr, input bit push, input bit pop,
                           input logic [W-1:0] din, input logic [DW-1:0] ds, input int cs, input bit os,
                           input logic [DW-1:0] dd, input int cd, input bit od);
        vecs[i].en = en; vecs[i].clr = clr; vecs[i].push = push; vecs[i].pop = pop; vecs[i].din = din;
        vecs[i].exp_data[0] = ds; vecs[i].exp_cnt[0] = cs; vecs[i].exp_ovf[0] = os;
        vecs[i].exp_data[1] = dd; vecs[i].exp_cnt[1] = cd; vecs[i].exp_ovf[1] = od;
    endtask

    initial begin
        //          en clr pu po din  sat: data    cnt ovf   drop: data   cnt ovf
        set_vec( 0, 1, 0, 1, 0, 4'h1, 16'h0001, 1, 0, 16'h0001, 1, 0);
        set_vec( 1, 1, 0, 1, 0, 4'h2, 16'h0012, 2, 0, 16'h0012, 2, 0);
        set_vec( 2, 1, 0, 1, 0, 4'h3, 16'h0123, 3, 0, 16'h0123, 3, 0);
        set_vec( 3, 1, 0, 1, 0, 4'h4, 16'h1234, 4, 0, 16'h1234, 4, 0);
        set_vec( 4, 1, 0, 1, 0, 4'h5, 16'h1234, 4, 1, 16'h2345, 4, 1);
        set_vec( 5, 1, 0, 1, 1, 4'hA, 16'h123A, 4, 1, 16'h234A, 4, 1);
        set_vec( 6, 0, 0, 1, 0, 4'h6, 16'h123A, 4, 1, 16'h234A, 4, 1);
        set_vec( 7, 1, 1, 1, 0, 4'h9, 16'h0000, 0, 0, 16'h0000, 0, 0);
        set_vec( 8, 1, 0, 1, 0, 4'h7, 16'h0007, 1, 0, 16'h0007, 1, 0);
        set_vec( 9, 1, 0, 1, 0, 4'h8, 16'h0078, 2, 0, 16'h0078, 2, 0);
        set_vec(10, 1, 0, 1, 0, 4'h9, 16'h0789, 3, 0, 16'h0789, 3, 0);
        set_vec(11, 1, 0, 0, 1, 4'h0, 16'h0078, 2, 0, 16'h0078, 2, 0);
        set_vec(12, 1, 0, 1, 1, 4'hA, 16'h007A, 2, 0, 16'h007A, 2, 0);
        set_vec(13, 1, 0, 0, 1, 4'h0, 16'h0007, 1, 0, 16'h0007, 1, 0);
        set_vec(14, 1, 0, 0, 1, 4'h0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        set_vec(15, 1, 0, 0, 1, 4'h0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        set_vec(16, 1, 0, 1, 1, 4'h3, 16'h0003, 1, 0, 16'h0003, 1, 0);
        set_vec(17, 0, 1, 0, 0, 4'h0, 16'h0000, 0, 0, 16'h0000, 0, 0);

        if_sat.en = 0;  if_sat.clr = 0;  if_sat.push = 0;  if_sat.pop = 0;  if_sat.dataIn = '0;
        if_drop.en = 0; if_drop.clr = 0; if_drop.push = 0; if_drop.pop = 0; if_drop.dataIn = '0;

        // Reset, then three idle cycles.
        #2 rst = 1'b1;
        #10 rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) check_dut(k, "reset", '0, 0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
            check_model("idle");
        end

        // Directed table: fill, overflow, replace while full, enable, clr, backspace.
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].din);
            for (int k = 0; k < 2; k++)
                check_dut(k, $sformatf("vec%0d", i), vecs[i].exp_data[k], vecs[i].exp_cnt[k], vecs[i].exp_ovf[k]);
        end

        // Asynchronous reset with count=3, asserted between clock edges.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h3);
        check_model("pre-rst");
        @(negedge clk);
        if_sat.push = 0; if_drop.push = 0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) check_dut(k, "async-rst", '0, 0, 1'b0);
        #1 rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'hC);
        check_model("post-rst");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 W'($urandom));
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
